// File: rtl/cache_data_array.sv
// Multi-line cache data store: byte-enabled CPU word writes, registered whole-line reads, burst line refill.
// Latency: reads return 1 cycle after rdEn; writes and refill beats land on the edge they are presented.
// Backpressure: wrStall rejects CPU writes to the line under refill; fillReady gates refill beats (high only in FILL).
//
// Ports:
//   clk, reset (async, active-low)
//   rdEn/rdIdx        -> rdLine/rdValid   registered line read
//   regWrite/wrIdx/wrWordOff/wrByteEn/wrData -> wrStall  CPU word write
//   fillStart/fillIdx/fillValid/fillData -> fillReady/fillDone/busy  refill burst
module cache_data_array #(
  parameter int NUM_LINES  = 8,
  parameter int LINE_BYTES = 32,
  parameter int WORD_BYTES = 4,
  parameter int BEAT_BYTES = 8,
  localparam int IDX_W  = $clog2(NUM_LINES),
  localparam int WOFF_W = $clog2(LINE_BYTES / WORD_BYTES),
  localparam int LINE_W = LINE_BYTES * 8,
  localparam int WORD_W = WORD_BYTES * 8,
  localparam int BEAT_W = BEAT_BYTES * 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rdEn,
  input  logic [IDX_W-1:0]  rdIdx,
  output logic [LINE_W-1:0] rdLine,
  output logic              rdValid,
  input  logic              regWrite,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [WOFF_W-1:0] wrWordOff,
  input  logic [WORD_BYTES-1:0] wrByteEn,
  input  logic [WORD_W-1:0] wrData,
  output logic              wrStall,
  input  logic              fillStart,
  input  logic [IDX_W-1:0]  fillIdx,
  input  logic              fillValid,
  input  logic [BEAT_W-1:0] fillData,
  output logic              fillReady,
  output logic              fillDone,
  output logic              busy
);

  localparam int BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_e;

  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    beat_q, beat_d;
  logic [IDX_W-1:0]                    fill_idx_q, fill_idx_d;
  logic [NUM_LINES-1:0][LINE_W-1:0]    mem_q;
  logic [LINE_W-1:0]                   rd_line_q;
  logic                                rd_valid_q;
  logic                                cpu_we;
  logic                                beat_acc;

  assign busy     = (state_q != ST_IDLE);
  // Only the line being refilled is protected; other lines stay writable.
  assign wrStall  = regWrite && busy && (wrIdx == fill_idx_q);
  assign cpu_we   = regWrite && !wrStall;
  assign beat_acc = (state_q == ST_FILL) && fillValid;
  assign rdLine   = rd_line_q;
  assign rdValid  = rd_valid_q;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    fill_idx_d = fill_idx_q;
    fillReady  = 1'b0;
    fillDone   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fillStart) begin
          fill_idx_d = fillIdx;
          beat_d     = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        fillReady = 1'b1;
        if (fillValid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == CNT_W'(BEATS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // fillStart is deliberately not sampled here.
        fillDone = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      fill_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      fill_idx_q <= fill_idx_d;
    end
  end

  // Read samples the array before this edge's writes, giving read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_line_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rdEn;
      if (rdEn) begin
        rd_line_q <= mem_q[rdIdx];
      end
    end
  end

  // A CPU write and a beat never target the same line in one cycle (wrStall),
  // so per-byte decode of both sources cannot collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LINES; l++) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
          if (cpu_we && (wrIdx == IDX_W'(l)) &&
              (wrWordOff == WOFF_W'(b / WORD_BYTES)) && wrByteEn[b % WORD_BYTES]) begin
            mem_q[l][b*8 +: 8] <= wrData[(b % WORD_BYTES)*8 +: 8];
          end
          if (beat_acc && (fill_idx_q == IDX_W'(l)) &&
              (beat_q == CNT_W'(b / BEAT_BYTES))) begin
            mem_q[l][b*8 +: 8] <= fillData[(b % BEAT_BYTES)*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: doc/cache_data_array.md
Name: cache_data_array

Overview:
- Parametrised multi-line cache data store. Successor to the single 256-bit line register.
- Holds NUM_LINES lines of LINE_BYTES bytes each.
- CPU side: byte-enabled word writes and whole-line registered reads.
- Memory side: burst line refill run by a beat-counting fill FSM with a valid/ready handshake. Sits between the tag/control logic and the memory interface.

Parameters:
- NUM_LINES, 8, number of cache lines (power of 2, ≥2); IDX_W = clog2(NUM_LINES)
- LINE_BYTES, 32, bytes per line (power of 2)
- WORD_BYTES, 4, bytes per CPU write word (power of 2, divides LINE_BYTES); WOFF_W = clog2(LINE_BYTES/WORD_BYTES)
- BEAT_BYTES, 8, bytes per refill beat (power of 2, divides LINE_BYTES); BEATS = LINE_BYTES/BEAT_BYTES ≥ 2

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- rdEn  in  1  read request
- rdIdx  in  IDX_W  line to read
- rdLine  out  LINE_BYTES*8  registered read data
- rdValid  out  1  rdLine updated this cycle
- regWrite  in  1  CPU word write request
- wrIdx  in  IDX_W  line to write
- wrWordOff  in  WOFF_W  word offset within line
- wrByteEn  in  WORD_BYTES  per-byte write enable
- wrData  in  WORD_BYTES*8  write data; byte b lands at line byte wrWordOff*WORD_BYTES+b
- wrStall  out  1  combinational; write this cycle rejected
- fillStart  in  1  begin refill
- fillIdx  in  IDX_W  line to refill
- fillValid  in  1  beat data valid
- fillData  in  BEAT_BYTES*8  beat data; beat k fills bytes k*BEAT_BYTES..(k+1)*BEAT_BYTES-1
- fillReady  out  1  beat accepted when fillValid && fillReady
- fillDone  out  1  one-cycle pulse after the last beat is written
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (reset=0, async):
  - All storage bytes are 0.
  - rdLine=0, rdValid=0.
  - FSM=IDLE, beat counter=0, latched fill index=0.
  - fillReady=0, fillDone=0, busy=0.
  - Reset asserted mid-fill aborts the fill; no fillDone is produced.
- Read:
  - On an edge with rdEn=1, rdLine <= line[rdIdx] and rdValid <= 1. Otherwise rdValid <= 0 and rdLine holds.
  - Latency is 1 cycle.
  - Read-before-write: a same-cycle write or fill beat to the read line is not visible until the next read.
- CPU write:
  - wrStall = regWrite && busy && (wrIdx == latched fill index).
  - If regWrite && !wrStall, each byte with wrByteEn[b]=1 is written on the edge. Bytes with enable 0 keep their value.
  - A stalled write has no effect; the requester must hold and retry.
  - wrByteEn=0 is a legal no-op.
- Fill FSM:
  - IDLE:
    - fillReady=0.
    - fillStart=1 latches fillIdx, clears the beat counter, and moves to FILL.
  - FILL:
    - fillReady=1.
    - On each fillValid, write beat slot [counter] and increment the counter.
    - Gaps with fillValid=0 are allowed; the FSM holds.
    - Accepting beat BEATS-1 moves to DONE.
  - DONE:
    - fillDone=1 and fillReady=0 for exactly one cycle, then IDLE.
  - fillStart is ignored outside IDLE.
  - busy=1 in FILL and DONE.
  - fillValid is ignored outside FILL.
- Concurrency:
  - A CPU write to a non-fill line proceeds in parallel with fill beats.
  - A CPU write to the fill line cannot coincide with a beat because it is stalled.
  - Reads are never stalled. Reading the fill line mid-fill returns partially refilled contents.
- Back-to-back: fillStart asserted in the DONE cycle is ignored. The earliest next start is the following cycle, in IDLE.

Test Plan:
- Reset then read all lines:
  - Reset low 2 cycles, release, rdEn=1 for idx 0..7 → rdLine=0 each, rdValid high 1 cycle after each request.
  - Assert reset mid-fill → FSM returns to IDLE, storage clears, no fillDone.
- Byte-enable write:
  - wrIdx=3, wrWordOff=2, wrByteEn=4'b0101, wrData=32'hAABBCCDD.
  - Read line 3 → bytes 8=DD and 10=BB; bytes 9 and 11 unchanged (0); all others 0.
- Refill with gaps:
  - fillStart, fillIdx=5, then 4 beats 64'h1111…, 2222…, 3333…, 4444… with one idle cycle between beats 2 and 3.
  - fillReady high only in FILL; fillDone pulses exactly once, 1 cycle after beat 4.
  - Line 5 = {4444…,3333…,2222…,1111…}.
- Write conflict:
  - During a fill of line 5, regWrite to line 5 → wrStall=1, line 5 unchanged.
  - Same-cycle write to line 2 → wrStall=0, written.
- Read-before-write:
  - rdEn and regWrite to line 1 in the same cycle → rdLine shows old data; next read shows new data.
- Ignored start:
  - fillStart with fillIdx=2 during an active fill of line 5 → latched index stays 5, line 2 untouched, only one fillDone.
